// File: rtl/m_move_history_if.sv
// m_move_history_if: drop/undo bus between game control and the move-history block.
// i_clear exists only when HISTORY_CLEAR_EN is defined.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 3
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif
interface m_move_history_if #(
    parameter int DEPTH_W = 6
);
    logic                               i_push_valid;
    logic [`COL_SIZE-1:0]               i_push_col;
    logic                               o_push_ready;
    logic                               i_undo_req;
    logic [`PILED_COUNT_ARRAY_SIZE-1:0] i_piled_count_array;
    logic                               o_undo_valid;
    logic [`COL_SIZE-1:0]               o_undo_col;
    logic [`ROW_SIZE-1:0]               o_undo_row;
    logic [`PILED_COUNT_ARRAY_SIZE-1:0] o_piled_counter;
    logic [DEPTH_W-1:0]                 o_depth;
    logic                               o_empty;
    logic                               o_full;
    logic                               o_error;
`ifdef HISTORY_CLEAR_EN
    logic                               i_clear;
    modport master (
        output i_push_valid, i_push_col, i_undo_req, i_piled_count_array, i_clear,
        input  o_push_ready, o_undo_valid, o_undo_col, o_undo_row, o_piled_counter,
        input  o_depth, o_empty, o_full, o_error
    );
    modport slave (
        input  i_push_valid, i_push_col, i_undo_req, i_piled_count_array, i_clear,
        output o_push_ready, o_undo_valid, o_undo_col, o_undo_row, o_piled_counter,
        output o_depth, o_empty, o_full, o_error
    );
`else
    modport master (
        output i_push_valid, i_push_col, i_undo_req, i_piled_count_array,
        input  o_push_ready, o_undo_valid, o_undo_col, o_undo_row, o_piled_counter,
        input  o_depth, o_empty, o_full, o_error
    );
    modport slave (
        input  i_push_valid, i_push_col, i_undo_req, i_piled_count_array,
        output o_push_ready, o_undo_valid, o_undo_col, o_undo_row, o_piled_counter,
        output o_depth, o_empty, o_full, o_error
    );
`endif
endinterface

// File: rtl/m_move_history.sv
// m_move_history: LIFO of dropped columns with an undo path that decrements the popped column's piled count.
// Optional HISTORY_CLEAR_EN adds i_clear, which wipes the history from IDLE.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 3
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif
module m_move_history #(
    parameter int DEPTH   = 42,
    parameter int DEPTH_W = 6
) (
    input logic             i_clk,
    input logic             i_rst,
    m_move_history_if.slave h
);
    typedef enum logic [1:0] {IDLE, POP, DONE} state_t;
    state_t                             state;
    logic [`COL_SIZE-1:0]               stack [DEPTH];
    logic [DEPTH_W-1:0]                 depth;
    logic [`COL_SIZE-1:0]               col;
    logic [4:0]                         base;
    logic [2:0]                         cnt;
    logic [`PILED_COUNT_ARRAY_SIZE-1:0] dec_arr;
    logic                               clear;
    logic                               full;
    logic                               take_undo;
    logic                               take_push;
`ifdef HISTORY_CLEAR_EN
    assign clear = h.i_clear;
`else
    assign clear = 1'b0;
`endif
    assign full           = depth == DEPTH_W'(DEPTH);
    assign h.o_depth      = depth;
    assign h.o_empty      = depth == '0;
    assign h.o_full       = full;
    assign h.o_push_ready = state == IDLE && !full && !h.i_undo_req && !clear;
    assign take_undo      = state == IDLE && !clear && h.i_undo_req && depth != '0;
    assign take_push      = h.o_push_ready && h.i_push_valid && h.i_push_col < `COL_SIZE'(7);
    assign base           = {2'b00, col} * 5'd3;
    assign cnt            = h.i_piled_count_array[base +: 3];
    always_comb begin
        dec_arr = h.i_piled_count_array;
        dec_arr[base +: 3] = cnt - 3'd1;
    end
    // Stack contents need no reset; depth alone defines what is valid.
    always_ff @(posedge i_clk) begin
        if (take_push) stack[depth] <= h.i_push_col;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE;
            depth             <= '0;
            col               <= '0;
            h.o_undo_valid    <= 1'b0;
            h.o_undo_col      <= '0;
            h.o_undo_row      <= '0;
            h.o_piled_counter <= '0;
            h.o_error         <= 1'b0;
        end else begin
            h.o_undo_valid <= 1'b0;
            h.o_error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) depth <= '0;
                    else if (take_undo) begin
                        col   <= stack[depth - DEPTH_W'(1)];
                        depth <= depth - DEPTH_W'(1);
                        state <= POP;
                    end
                    else if (h.i_undo_req) h.o_error <= 1'b1;
                    else if (take_push) depth <= depth + DEPTH_W'(1);
                    else if (h.o_push_ready && h.i_push_valid) h.o_error <= 1'b1;
                end
                POP: begin
                    // A zero count means history and board disagree: report, keep old outputs.
                    state     <= cnt == '0 ? IDLE : DONE;
                    h.o_error <= cnt == '0;
                    if (cnt != '0) begin
                        h.o_undo_col      <= col;
                        h.o_undo_row      <= `ROW_SIZE'(cnt - 3'd1);
                        h.o_piled_counter <= dec_arr;
                    end
                end
                DONE: begin
                    h.o_undo_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_move_history.sv
// tb_m_move_history: random and directed stimulus checked each cycle against a queue-based history model.
// Build with HISTORY_CLEAR_EN defined to exercise i_clear as well.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 3
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif
module tb_m_move_history;
    localparam int DEPTH = 42;
    logic clk = 1'b0;
    logic rst = 1'b1;
    m_move_history_if #(.DEPTH_W(6)) bus();
    m_move_history #(.DEPTH(DEPTH), .DEPTH_W(6)) dut (.i_clk(clk), .i_rst(rst), .h(bus));
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    int hist[$];
    int busy = 0;
    int pcol = 0;
    logic e_err = 1'b0;
    logic e_valid = 1'b0;
    logic [2:0] e_col = '0;
    logic [2:0] e_row = '0;
    logic [20:0] e_arr = '0;
    logic pv = 1'b0;
    logic ur = 1'b0;
    logic clr = 1'b0;
    logic [2:0] pc = '0;
    logic [20:0] arr = '0;
    assign bus.i_push_valid = pv;
    assign bus.i_push_col = pc;
    assign bus.i_undo_req = ur;
    assign bus.i_piled_count_array = arr;
`ifdef HISTORY_CLEAR_EN
    assign bus.i_clear = clr;
`endif
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        hist.delete();
        busy = 0;
        e_err = 1'b0;
        e_valid = 1'b0;
        e_col = '0;
        e_row = '0;
        e_arr = '0;
    endtask
    // busy counts the edges left before the block is idle again after taking an undo
    task automatic model_step();
        int cnt;
        e_err = 1'b0;
        e_valid = 1'b0;
        if (busy == 0) begin
            if (clr) hist.delete();
            else if (ur) begin
                if (hist.size() == 0) e_err = 1'b1;
                else begin
                    pcol = hist.pop_back();
                    busy = 2;
                end
            end else if (pv && hist.size() < DEPTH) begin
                if (pc < 7) hist.push_back(int'(pc));
                else e_err = 1'b1;
            end
        end else if (busy == 2) begin
            cnt = int'((arr >> (3 * pcol)) & 21'd7);
            if (cnt == 0) begin
                e_err = 1'b1;
                busy = 0;
            end else begin
                e_col = 3'(pcol);
                e_row = 3'(cnt - 1);
                e_arr = arr - (21'd1 << (3 * pcol));
                busy = 1;
            end
        end else begin
            e_valid = 1'b1;
            busy = 0;
        end
    endtask
    task automatic step(input logic npv, input logic [2:0] npc, input logic nur);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        pv = npv;
        pc = npc;
        ur = nur;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step(1'b0, 3'd0, 1'b0);
        rst = 1'b0;
    endtask
    initial forever begin
        @(negedge clk);
        check("depth", 32'(bus.o_depth), 32'(hist.size()));
        check("empty", 32'(bus.o_empty), 32'(hist.size() == 0));
        check("full", 32'(bus.o_full), 32'(hist.size() == DEPTH));
        check("ready", 32'(bus.o_push_ready), 32'(busy == 0 && hist.size() < DEPTH && !ur && !clr));
        check("valid", 32'(bus.o_undo_valid), 32'(e_valid));
        check("error", 32'(bus.o_error), 32'(e_err));
        check("undo_col", 32'(bus.o_undo_col), 32'(e_col));
        check("undo_row", 32'(bus.o_undo_row), 32'(e_row));
        check("piled", 32'(bus.o_piled_counter), 32'(e_arr));
    end
    initial begin
        logic [20:0] ra;
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        // undo on empty history
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        check("empty_undo_err", 32'(bus.o_error), 32'd1);
        check("empty_undo_valid", 32'(bus.o_undo_valid), 32'd0);
        check("empty_undo_depth", 32'(bus.o_depth), 32'd0);
        check("empty_undo_empty", 32'(bus.o_empty), 32'd1);
        step(1'b0, 3'd0, 1'b0);
        check("empty_undo_err_once", 32'(bus.o_error), 32'd0);
        // push 3,3,5 then undo with col3=2, col5=1
        arr = 21'o0102000;
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("lat_valid_early", 32'(bus.o_undo_valid), 32'd0);
        step(1'b0, 3'd0, 1'b0);
        check("lat_valid", 32'(bus.o_undo_valid), 32'd1);
        check("undo_col_5", 32'(bus.o_undo_col), 32'd5);
        check("undo_row_0", 32'(bus.o_undo_row), 32'd0);
        check("piled_335", 32'(bus.o_piled_counter), 32'o0002000);
        check("depth_2", 32'(bus.o_depth), 32'd2);
        // fill to full, overflow push, undo from full
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i % 7), 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("full_depth", 32'(bus.o_depth), 32'd42);
        check("full_flag", 32'(bus.o_full), 32'd1);
        check("full_ready", 32'(bus.o_push_ready), 32'd0);
        arr = 21'o6666666;
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        check("unfull_depth", 32'(bus.o_depth), 32'd41);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("unfull_ready", 32'(bus.o_push_ready), 32'd1);
        check("unfull_col", 32'(bus.o_undo_col), 32'd6);
        // column 7 push is rejected
        step(1'b1, 3'd7, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("col7_err", 32'(bus.o_error), 32'd1);
        check("col7_depth", 32'(bus.o_depth), 32'd41);
        // top is column 5 with a zero count
        arr = 21'o6066666;
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("zero_err", 32'(bus.o_error), 32'd1);
        check("zero_valid", 32'(bus.o_undo_valid), 32'd0);
        check("zero_depth", 32'(bus.o_depth), 32'd40);
        check("zero_hold_col", 32'(bus.o_undo_col), 32'd6);
        step(1'b0, 3'd0, 1'b0);
        check("zero_no_valid", 32'(bus.o_undo_valid), 32'd0);
        // simultaneous push and undo, then reset during POP
        arr = 21'o6666666;
        step(1'b1, 3'd3, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        check("simul_depth", 32'(bus.o_depth), 32'd39);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_pop_depth", 32'(bus.o_depth), 32'd0);
        step(1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("rst_pop_no_valid", 32'(bus.o_undo_valid), 32'd0);
`ifdef HISTORY_CLEAR_EN
        for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("clr_pre_depth", 32'(bus.o_depth), 32'd4);
        step(1'b0, 3'd0, 1'b1);
        clr = 1'b1;
        step(1'b0, 3'd0, 1'b0);
        clr = 1'b0;
        check("clr_depth", 32'(bus.o_depth), 32'd0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("clr_no_valid", 32'(bus.o_undo_valid), 32'd0);
`endif
        // randomized traffic: push-heavy first half, undo-heavy second half
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int pb;
            int ub;
            pb = n < 2000 ? 75 : 40;
            ub = n < 2000 ? 10 : 35;
            step($urandom_range(0, 99) < pb, 3'($urandom_range(0, 7)), $urandom_range(0, 99) < ub);
`ifdef HISTORY_CLEAR_EN
            clr = $urandom_range(0, 99) < 2;
`endif
            if (busy == 0) begin
                for (int c = 0; c < 7; c++) ra[c*3 +: 3] = 3'($urandom_range(0, 6));
                arr = ra;
            end
            if ($urandom_range(0, 999) < 3) do_reset();
        end
        clr = 1'b0;
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
